// File: rtl/cu_pkg.sv
// Shared definitions for the microcoded control unit: state encoding,
// default parameter values and reserved-slot / microword layout helpers.
package cu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } cu_state_e;

    localparam int unsigned DEF_INS_W  = 8;
    localparam int unsigned DEF_CS_W   = 34;
    localparam int unsigned DEF_N_OPS  = 64;
    localparam int unsigned DEF_STEP_W = 2;
    localparam int unsigned DEF_NOP_OP = 37;
    localparam int unsigned DEF_END_OP = 38;
    localparam int unsigned DEF_JNZ_OP = 40;
    localparam int unsigned DEF_XC_MIN = 8;

    // The last two slots are reserved for the start-up and fetch sequences.
    function automatic int unsigned start_slot(input int unsigned n_ops);
        return n_ops - 2;
    endfunction

    function automatic int unsigned fetch_slot(input int unsigned n_ops);
        return n_ops - 1;
    endfunction

    // The end-of-slot flag sits directly above the control word.
    function automatic int unsigned last_bit(input int unsigned cs_w);
        return cs_w;
    endfunction

endpackage

// File: rtl/ucode_store.sv
// Microcode RAM: synchronous write, combinational read, no reset.
module ucode_store #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 35
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/param_control_unit.sv
// Microcoded sequencer: steps through {slot,step} microwords, dispatches on
// the fetched opcode, and exposes the current control word.
module param_control_unit
    import cu_pkg::*;
#(
    parameter int unsigned INS_W  = DEF_INS_W,
    parameter int unsigned CS_W   = DEF_CS_W,
    parameter int unsigned N_OPS  = DEF_N_OPS,
    parameter int unsigned STEP_W = DEF_STEP_W,
    parameter int unsigned NOP_OP = DEF_NOP_OP,
    parameter int unsigned END_OP = DEF_END_OP,
    parameter int unsigned JNZ_OP = DEF_JNZ_OP,
    parameter int unsigned XC_MIN = DEF_XC_MIN,
    localparam int unsigned SLOT_W = $clog2(N_OPS),
    localparam int unsigned AW     = SLOT_W + STEP_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      status,
    input  logic [INS_W-1:0] ins,
    input  logic            z,
    input  logic            xc,
    input  logic            mem_ready,
    input  logic            ucode_we,
    input  logic [AW-1:0]   ucode_waddr,
    input  logic [CS_W:0]   ucode_wdata,
    output logic [CS_W-1:0] control_signal,
    output logic            end_process,
    output logic            busy,
    output logic            illegal_op
);

    localparam int unsigned LAST_BIT = last_bit(CS_W);

    localparam logic [SLOT_W-1:0] START_SLOT = SLOT_W'(start_slot(N_OPS));
    localparam logic [SLOT_W-1:0] FETCH_SLOT = SLOT_W'(fetch_slot(N_OPS));
    localparam logic [SLOT_W-1:0] NOP_SLOT   = SLOT_W'(NOP_OP);
    localparam logic [SLOT_W-1:0] END_SLOT   = SLOT_W'(END_OP);
    localparam logic [SLOT_W-1:0] JNZ_SLOT0  = SLOT_W'(JNZ_OP);
    localparam logic [SLOT_W-1:0] JNZ_SLOT1  = SLOT_W'(JNZ_OP + 1);
    localparam logic [STEP_W-1:0] STEP_MAX   = '1;

    localparam logic [INS_W-1:0] ILL_MIN = INS_W'(N_OPS - 2);
    localparam logic [INS_W-1:0] XC_LIM  = INS_W'(XC_MIN);
    localparam logic [INS_W-1:0] END_INS = INS_W'(END_OP);
    localparam logic [INS_W-1:0] JNZ_INS = INS_W'(JNZ_OP);

    cu_state_e           state, state_nx;
    logic [SLOT_W-1:0]   slot, slot_nx;
    logic [STEP_W-1:0]   step, step_nx;
    logic                illegal_nx;
    logic                end_nx;
    logic [CS_W:0]       rd_word;
    logic                last;

    ucode_store #(
        .AW (AW),
        .DW (CS_W + 1)
    ) u_store (
        .clk   (clk),
        .we    (ucode_we && !busy),
        .waddr (ucode_waddr),
        .wdata (ucode_wdata),
        .raddr ({slot, step}),
        .rdata (rd_word)
    );

    assign last           = rd_word[LAST_BIT];
    assign busy           = (state == ST_RUN);
    assign control_signal = busy ? rd_word[CS_W-1:0] : '0;
    // Only flag completion once DONE persists, so IDLE never sees end_process.
    assign end_nx         = (state == ST_DONE) && (state_nx == ST_DONE);

    // Next-state: sequencing within a slot, then dispatch between slots.
    always_comb begin
        state_nx   = state;
        slot_nx    = slot;
        step_nx    = step;
        illegal_nx = illegal_op;
        case (state)
            ST_IDLE: begin
                if (status == 2'b01) begin
                    state_nx   = ST_RUN;
                    slot_nx    = START_SLOT;
                    step_nx    = '0;
                    illegal_nx = 1'b0;
                end
            end
            ST_RUN: begin
                if (mem_ready) begin
                    if (!last && (step != STEP_MAX)) begin
                        step_nx = step + STEP_W'(1);
                    end else begin
                        step_nx = '0;
                        if (slot == FETCH_SLOT) begin
                            if (ins >= ILL_MIN) begin
                                illegal_nx = 1'b1;
                                slot_nx    = NOP_SLOT;
                            end else if ((ins >= XC_LIM) && !xc) begin
                                slot_nx = NOP_SLOT;
                            end else if (ins == END_INS) begin
                                if (z) begin
                                    state_nx = ST_DONE;
                                end else begin
                                    slot_nx = END_SLOT;
                                end
                            end else if (ins == JNZ_INS) begin
                                slot_nx = z ? JNZ_SLOT1 : JNZ_SLOT0;
                            end else begin
                                slot_nx = SLOT_W'(ins);
                            end
                        end else begin
                            slot_nx = FETCH_SLOT;
                        end
                    end
                end
            end
            ST_DONE: begin
                if (status == 2'b00) begin
                    state_nx = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            slot        <= '0;
            step        <= '0;
            illegal_op  <= 1'b0;
            end_process <= 1'b0;
        end else begin
            state       <= state_nx;
            slot        <= slot_nx;
            step        <= step_nx;
            illegal_op  <= illegal_nx;
            end_process <= end_nx;
        end
    end

endmodule

// File: tb/tb_param_control_unit.sv
// Scoreboard bench for param_control_unit: expected control words are queued
// as each instruction is driven and compared cycle by cycle.
module tb_param_control_unit;

    localparam int unsigned CS_W = 34;
    localparam int unsigned AW   = 8;

    logic            clk;
    logic            rst;
    logic [1:0]      status;
    logic [7:0]      ins;
    logic            z;
    logic            xc;
    logic            mem_ready;
    logic            ucode_we;
    logic [AW-1:0]   ucode_waddr;
    logic [CS_W:0]   ucode_wdata;
    logic [CS_W-1:0] control_signal;
    logic            end_process;
    logic            busy;
    logic            illegal_op;

    logic [CS_W-1:0] sb[$];
    int              n_checks = 0;
    int              n_errors = 0;

    param_control_unit dut (
        .clk            (clk),
        .rst            (rst),
        .status         (status),
        .ins            (ins),
        .z              (z),
        .xc             (xc),
        .mem_ready      (mem_ready),
        .ucode_we       (ucode_we),
        .ucode_waddr    (ucode_waddr),
        .ucode_wdata    (ucode_wdata),
        .control_signal (control_signal),
        .end_process    (end_process),
        .busy           (busy),
        .illegal_op     (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic logic [CS_W-1:0] cs_of(input int slot, input int step);
        return {8'hA5, 16'(slot * 4 + step), 10'h3C1};
    endfunction

    task automatic wr(input int slot, input int step, input logic last);
        ucode_we    = 1'b1;
        ucode_waddr = {6'(slot), 2'(step)};
        ucode_wdata = {last, cs_of(slot, step)};
        @(negedge clk);
        ucode_we    = 1'b0;
    endtask

    task automatic prog_slot(input int slot, input int nw, input logic last_on_final);
        for (int s = 0; s < nw; s++) begin
            wr(slot, s, (s == nw - 1) ? last_on_final : 1'b0);
        end
    endtask

    task automatic push_slot(input int slot, input int nw);
        for (int s = 0; s < nw; s++) begin
            sb.push_back(cs_of(slot, s));
        end
    endtask

    task automatic consume(input int n);
        logic [CS_W-1:0] exp;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (sb.size() == 0) begin
                check_eq("sb_underflow", 64'd1, 64'd0);
            end else begin
                exp = sb.pop_front();
                check_eq("cs", 64'(control_signal), 64'(exp));
                check_eq("busy", 64'(busy), 64'd1);
            end
        end
    endtask

    task automatic run_instr(input int i, input logic zz, input logic x, input int tgt, input int nw);
        ins = 8'(i);
        z   = zz;
        xc  = x;
        push_slot(63, 2);
        push_slot(tgt, nw);
        consume(2 + nw);
    endtask

    initial begin
        rst         = 1'b1;
        status      = 2'b00;
        ins         = '0;
        z           = 1'b0;
        xc          = 1'b1;
        mem_ready   = 1'b1;
        ucode_we    = 1'b0;
        ucode_waddr = '0;
        ucode_wdata = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_cs", 64'(control_signal), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_end", 64'(end_process), 64'd0);
        check_eq("rst_ill", 64'(illegal_op), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        prog_slot(62, 1, 1'b1);
        prog_slot(63, 2, 1'b1);
        prog_slot(9, 2, 1'b1);
        prog_slot(40, 1, 1'b1);
        prog_slot(41, 1, 1'b1);
        prog_slot(37, 1, 1'b1);
        prog_slot(38, 1, 1'b1);
        prog_slot(5, 1, 1'b1);
        prog_slot(61, 1, 1'b1);
        prog_slot(20, 4, 1'b0);

        check_eq("idle_cs", 64'(control_signal), 64'd0);
        status = 2'b01;
        push_slot(62, 1);
        consume(1);

        run_instr(9, 1'b0, 1'b1, 9, 2);
        run_instr(40, 1'b0, 1'b1, 40, 1);
        run_instr(40, 1'b1, 1'b1, 41, 1);
        run_instr(12, 1'b0, 1'b0, 37, 1);
        check_eq("gate_no_ill", 64'(illegal_op), 64'd0);
        run_instr(5, 1'b0, 1'b0, 5, 1);
        run_instr(61, 1'b0, 1'b1, 61, 1);
        check_eq("ins61_no_ill", 64'(illegal_op), 64'd0);
        run_instr(70, 1'b0, 1'b1, 37, 1);
        check_eq("ill_70", 64'(illegal_op), 64'd1);

        // Stall mid-slot with a blocked write to the next word.
        ins = 8'd20;
        z   = 1'b0;
        xc  = 1'b1;
        push_slot(63, 2);
        push_slot(20, 2);
        consume(4);
        mem_ready   = 1'b0;
        ucode_we    = 1'b1;
        ucode_waddr = {6'd20, 2'd2};
        ucode_wdata = {1'b1, 34'd0};
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq("stall_cs", 64'(control_signal), 64'(cs_of(20, 1)));
            check_eq("stall_busy", 64'(busy), 64'd1);
        end
        ucode_we  = 1'b0;
        mem_ready = 1'b1;
        sb.push_back(cs_of(20, 2));
        sb.push_back(cs_of(20, 3));
        consume(2);

        // Reset asserted while slot 9 word A is on the output.
        ins = 8'd9;
        push_slot(63, 2);
        sb.push_back(cs_of(9, 0));
        consume(3);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_cs", 64'(control_signal), 64'd0);
        check_eq("mid_rst_busy", 64'(busy), 64'd0);
        check_eq("mid_rst_ill", 64'(illegal_op), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        push_slot(62, 1);
        consume(1);

        run_instr(62, 1'b0, 1'b1, 37, 1);
        check_eq("ill_62", 64'(illegal_op), 64'd1);

        // END with z=1 reaches DONE.
        ins = 8'd38;
        z   = 1'b1;
        push_slot(63, 2);
        consume(2);
        @(negedge clk);
        check_eq("done_cs", 64'(control_signal), 64'd0);
        check_eq("done_busy", 64'(busy), 64'd0);
        check_eq("done_end0", 64'(end_process), 64'd0);
        @(negedge clk);
        check_eq("done_end1", 64'(end_process), 64'd1);
        check_eq("done_cs2", 64'(control_signal), 64'd0);
        status = 2'b00;
        @(negedge clk);
        check_eq("ack_end", 64'(end_process), 64'd0);
        check_eq("ack_busy", 64'(busy), 64'd0);
        @(negedge clk);
        check_eq("idle_end", 64'(end_process), 64'd0);

        // Restart clears the sticky flag; END with z=0 runs slot 38.
        status = 2'b01;
        push_slot(62, 1);
        consume(1);
        check_eq("restart_ill", 64'(illegal_op), 64'd0);
        run_instr(38, 1'b0, 1'b1, 38, 1);
        check_eq("end_z0_busy", 64'(busy), 64'd1);

        check_eq("sb_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/param_control_unit.md
PARAM_CONTROL_UNIT -- requirements
Module: param_control_unit

Interface
REQ-001 Parameter INS_W, default 8, opcode width.
REQ-002 Parameter CS_W, default 34, control word width.
REQ-003 Parameter N_OPS, default 64, number of microcode slots; power of two, at most 2^INS_W.
REQ-004 Parameter STEP_W, default 2, step-index width; each slot holds 2^STEP_W microwords.
REQ-005 Parameters NOP_OP 37, END_OP 38, JNZ_OP 40, XC_MIN 8; START_SLOT = N_OPS-2 and FETCH_SLOT = N_OPS-1 are reserved.
REQ-006 Derived AW = log2(N_OPS)+STEP_W is the microcode address width; a microword is {last, cs[CS_W-1:0]}.
REQ-007 clk  in  1  single clock; all state updates on the rising edge.
REQ-008 rst  in  1  asynchronous, active-high reset.
REQ-009 status  in  2  run request; 2'b01 means start, 2'b00 means acknowledge done.
REQ-010 ins  in  INS_W  current opcode from the instruction register.
REQ-011 z  in  1  datapath zero flag.
REQ-012 xc  in  1  execute-enable; low forces opcodes >= XC_MIN to NOP.
REQ-013 mem_ready  in  1  datapath/memory ready; low stalls the sequencer.
REQ-014 ucode_we, ucode_waddr[AW], ucode_wdata[CS_W+1]  in  microcode write port.
REQ-015 control_signal  out  CS_W  current control word.
REQ-016 end_process  out  1  program finished.
REQ-017 busy  out  1  sequencer running.
REQ-018 illegal_op  out  1  sticky flag for an undecodable opcode.

Function
REQ-019 The block SHALL implement the states IDLE, RUN and DONE, with a slot register and a step register in RUN.
REQ-020 IDLE: control_signal=0; status==2'b01 SHALL enter RUN at {START_SLOT,0} and clear illegal_op.
REQ-021 In RUN, control_signal SHALL equal the cs field of the microword at {slot,step}, read combinationally in the same cycle.
REQ-022 RUN with mem_ready=1: when last=0 and step < max, step SHALL increment; otherwise the dispatch in REQ-024 applies and step SHALL go to 0.
REQ-023 RUN with mem_ready=0: slot, step and control_signal SHALL hold; a stall of any length is allowed.
REQ-024 Dispatch: from START_SLOT go to FETCH_SLOT; from FETCH_SLOT decode ins per REQ-025..028; from any other slot go to FETCH_SLOT.
REQ-025 Decode, first match wins: ins >= N_OPS-2 → set illegal_op and go to slot NOP_OP.
REQ-026 Decode: ins >= XC_MIN and xc=0 → slot NOP_OP.
REQ-027 Decode: ins==END_OP → DONE if z=1, else slot END_OP; ins==JNZ_OP → slot JNZ_OP+z.
REQ-028 Decode: any other opcode → slot ins.
REQ-029 ins and z SHALL be sampled at the clock edge that ends the last FETCH_SLOT word.
REQ-030 DONE: control_signal=0 and end_process=1 on every DONE cycle, registered so it rises one cycle after DONE is entered; status==2'b00 returns to IDLE.
REQ-031 busy SHALL be 1 exactly in RUN.
REQ-032 A microcode write SHALL occur at the clock edge only when ucode_we=1 and busy=0; writes while busy SHALL be ignored, and the new word is readable the next cycle.

Reset
REQ-033 While rst=1: state=IDLE, slot=0, step=0, control_signal=0, end_process=0, illegal_op=0, taking effect immediately including mid-RUN.
REQ-034 Microcode contents SHALL NOT be affected by rst and are undefined after power-up until written.

Structure
REQ-035 Package cu_pkg SHALL hold the state enum, the default parameter values, the reserved-slot constants and the LAST bit position (MSB of the microword).
REQ-036 Sub-module ucode_store SHALL hold 2^AW microwords with a synchronous write port and a combinational read port.

Verification
REQ-037 Reset scenario: assert rst during a RUN slot-9 word → control_signal=0 at once and state=IDLE; deassert with status=01 → {START_SLOT,0}.
REQ-038 Sequencing scenario: program slot 9 as {0,A},{1,B}; ins=9, xc=1 → fetch words, then A, B, then fetch again; busy=1 throughout.
REQ-039 Jump scenario: ins=40, z=0 → slot 40 words; ins=40, z=1 → slot 41 words.
REQ-040 End scenario: ins=38, z=1 → end_process=1 the cycle after DONE is entered; status=00 → IDLE with end_process=0.
REQ-041 Gating/illegal scenario: ins=12, xc=0 → slot 37; ins=70 → illegal_op=1 and slot 37; ins=5, xc=0 → slot 5.
REQ-042 Stall/write scenario: mem_ready=0 for 3 cycles mid-slot → control_signal constant and step unchanged; ucode_we while busy → contents unchanged.
